// File: rtl/xor_cipher_pkg.sv
// Shared types, default geometry and width helpers for the lane-wide XOR stream cipher.
// Optional build macro: XOR_CIPHER_KEY_ROLL_EN (see xor_key_ring).
package xor_cipher_pkg;

    typedef enum logic [1:0] {
        StNoKey,
        StLoadKey,
        StIdle,
        StRun
    } cipher_state_e;

    localparam int unsigned KEY_BITS_DEFAULT = 32;
    localparam int unsigned LANES_DEFAULT    = 8;
    localparam int unsigned MSG_BITS_DEFAULT = 512;

    localparam int unsigned KEY_BEATS = KEY_BITS_DEFAULT / LANES_DEFAULT;
    localparam int unsigned MSG_BEATS = MSG_BITS_DEFAULT / LANES_DEFAULT;

    // Width of a counter holding 0..n-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned KEY_PTR_W  = cnt_width(KEY_BEATS);
    localparam int unsigned BEAT_CNT_W = cnt_width(MSG_BEATS);

endpackage

// File: rtl/xor_key_ring.sv
// Key shift register, key beat counter and slice pointer for xor_stream_cipher.
// With XOR_CIPHER_KEY_ROLL_EN the key rotates per pass and is restored from a shadow at frame end.
module xor_key_ring
    import xor_cipher_pkg::*;
#(
    parameter int unsigned KEY_BITS = KEY_BITS_DEFAULT,
    parameter int unsigned LANES    = LANES_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             shift,
    input  logic [LANES-1:0] key_in,
    input  logic             advance,
    input  logic             frame_end,
    output logic             key_last,
    output logic [LANES-1:0] slice
);

    localparam int unsigned KeyBeats = KEY_BITS / LANES;
    localparam int unsigned PtrW     = cnt_width(KeyBeats);
    localparam logic [PtrW-1:0] PtrMax = PtrW'(KeyBeats - 1);

    logic [KEY_BITS-1:0] key_q, key_d;
    logic [PtrW-1:0]     cnt_q, cnt_d;
    logic [PtrW-1:0]     ptr_q, ptr_d;
    logic                ptr_wrap;

    assign ptr_wrap = advance && (ptr_q == PtrMax);
    assign key_last = (cnt_q == PtrMax);
    // MSB slice is served first: slice k sits at key[KEY_BITS-1-LANES*k -: LANES].
    assign slice    = LANES'(key_q >> (KEY_BITS - LANES * (int'(ptr_q) + 1)));

`ifdef XOR_CIPHER_KEY_ROLL_EN
    logic [KEY_BITS-1:0] shadow_q;
`endif

    always_comb begin
        key_d = key_q;
        cnt_d = cnt_q;
        ptr_d = ptr_q;
        if (shift) begin
            key_d = (key_q << LANES) | KEY_BITS'(key_in);
            cnt_d = key_last ? '0 : cnt_q + 1'b1;
        end
        if (advance) begin
            ptr_d = (frame_end || ptr_wrap) ? '0 : ptr_q + 1'b1;
        end
`ifdef XOR_CIPHER_KEY_ROLL_EN
        if (frame_end) begin
            key_d = shadow_q;
        end else if (ptr_wrap) begin
            key_d = (key_q << 1) | (key_q >> (KEY_BITS - 1));
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_q <= '0;
            cnt_q <= '0;
            ptr_q <= '0;
        end else begin
            key_q <= key_d;
            cnt_q <= cnt_d;
            ptr_q <= ptr_d;
        end
    end

`ifdef XOR_CIPHER_KEY_ROLL_EN
    // Shifts only happen between frames, when the working key equals the loaded one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow_q <= '0;
        end else if (shift) begin
            shadow_q <= key_d;
        end
    end
`endif

endmodule

// File: rtl/xor_stream_cipher.sv
// Lane-wide streaming XOR cipher: key load FSM, beat counter and one-deep output register.
// Optional build macro: XOR_CIPHER_KEY_ROLL_EN (per-pass key rotation, inside xor_key_ring).
module xor_stream_cipher
    import xor_cipher_pkg::*;
#(
    parameter int unsigned KEY_BITS = KEY_BITS_DEFAULT,
    parameter int unsigned LANES    = LANES_DEFAULT,
    parameter int unsigned MSG_BITS = MSG_BITS_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             key_load,
    input  logic [LANES-1:0] key_in,
    output logic             key_valid,
    input  logic             msg_valid,
    input  logic [LANES-1:0] msg_data,
    input  logic             msg_last,
    output logic             msg_ready,
    output logic             out_valid,
    output logic [LANES-1:0] out_data,
    output logic             out_last,
    input  logic             out_ready,
    output logic             frame_done,
    output logic             overflow
);

    localparam int unsigned MsgBeats = MSG_BITS / LANES;
    localparam int unsigned BeatW    = cnt_width(MsgBeats);
    localparam logic [BeatW-1:0] BeatMax = BeatW'(MsgBeats - 1);

    cipher_state_e    state_q, state_d;
    logic             key_valid_q, key_valid_d;
    logic [BeatW-1:0] beat_q;
    logic             out_valid_q, out_last_q, frame_done_q, overflow_q;
    logic [LANES-1:0] out_data_q;

    logic             accept, last_beat, frame_end, key_shift, key_last;
    logic [LANES-1:0] key_slice;

    assign msg_ready = ena && key_valid_q && (state_q inside {StIdle, StRun})
                       && (!out_valid_q || out_ready);
    assign accept    = msg_valid && msg_ready;
    assign last_beat = msg_last || (beat_q == BeatMax);
    assign frame_end = accept && last_beat;
    // An accepted beat in IDLE wins over a same-cycle rekey so the frame keeps its key.
    assign key_shift = ena && key_load
                       && ((state_q inside {StNoKey, StLoadKey}) || (state_q == StIdle && !accept));

    xor_key_ring #(
        .KEY_BITS(KEY_BITS),
        .LANES   (LANES)
    ) u_key_ring (
        .clk      (clk),
        .rst_n    (rst_n),
        .shift    (key_shift),
        .key_in   (key_in),
        .advance  (accept),
        .frame_end(frame_end),
        .key_last (key_last),
        .slice    (key_slice)
    );

    always_comb begin
        state_d     = state_q;
        key_valid_d = key_valid_q;
        unique case (state_q)
            StNoKey, StLoadKey, StIdle: begin
                if (key_shift) begin
                    key_valid_d = key_last;
                    state_d     = key_last ? StIdle : StLoadKey;
                end else if (state_q == StIdle && accept && !last_beat) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (frame_end) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StNoKey;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StNoKey;
            key_valid_q  <= 1'b0;
            beat_q       <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else if (ena) begin
            state_q      <= state_d;
            key_valid_q  <= key_valid_d;
            frame_done_q <= out_valid_q && out_ready && out_last_q;
            if (accept) begin
                out_data_q  <= msg_data ^ key_slice;
                out_valid_q <= 1'b1;
                out_last_q  <= last_beat;
                beat_q      <= last_beat ? '0 : beat_q + 1'b1;
                if (beat_q == BeatMax && !msg_last) begin
                    overflow_q <= 1'b1;
                end
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end
        end
    end

    assign key_valid  = key_valid_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_last   = out_last_q;
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_xor_stream_cipher.sv
// Directed bench for xor_stream_cipher: one default instance and one with MSG_BITS=32.
// Expectations follow XOR_CIPHER_KEY_ROLL_EN when the bench is built with it.
module tb_xor_stream_cipher;

`ifdef XOR_CIPHER_KEY_ROLL_EN
    localparam bit ROLL = 1'b1;
`else
    localparam bit ROLL = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, rst_b, ena, key_load, msg_valid, msg_last, out_ready;
    logic [7:0] key_in, msg_data;

    logic       a_key_valid, a_msg_ready, a_out_valid, a_out_last, a_frame_done, a_overflow;
    logic       b_key_valid, b_msg_ready, b_out_valid, b_out_last, b_frame_done, b_overflow;
    logic [7:0] a_out_data, b_out_data;

    xor_stream_cipher #(.KEY_BITS(32), .LANES(8), .MSG_BITS(512)) dut_a (
        .clk(clk), .rst_n(rst_a), .ena(ena), .key_load(key_load), .key_in(key_in),
        .key_valid(a_key_valid), .msg_valid(msg_valid), .msg_data(msg_data),
        .msg_last(msg_last), .msg_ready(a_msg_ready), .out_valid(a_out_valid),
        .out_data(a_out_data), .out_last(a_out_last), .out_ready(out_ready),
        .frame_done(a_frame_done), .overflow(a_overflow)
    );

    xor_stream_cipher #(.KEY_BITS(32), .LANES(8), .MSG_BITS(32)) dut_b (
        .clk(clk), .rst_n(rst_b), .ena(ena), .key_load(key_load), .key_in(key_in),
        .key_valid(b_key_valid), .msg_valid(msg_valid), .msg_data(msg_data),
        .msg_last(msg_last), .msg_ready(b_msg_ready), .out_valid(b_out_valid),
        .out_data(b_out_data), .out_last(b_out_last), .out_ready(out_ready),
        .frame_done(b_frame_done), .overflow(b_overflow)
    );

    logic       sel;
    logic       o_key_valid, o_msg_ready, o_out_valid, o_out_last, o_frame_done, o_overflow;
    logic [7:0] o_out_data;
    assign o_key_valid  = sel ? b_key_valid  : a_key_valid;
    assign o_msg_ready  = sel ? b_msg_ready  : a_msg_ready;
    assign o_out_valid  = sel ? b_out_valid  : a_out_valid;
    assign o_out_data   = sel ? b_out_data   : a_out_data;
    assign o_out_last   = sel ? b_out_last   : a_out_last;
    assign o_frame_done = sel ? b_frame_done : a_frame_done;
    assign o_overflow   = sel ? b_overflow   : a_overflow;

    int checks = 0;
    int failures = 0;

    logic [7:0] msg_v[8];
    logic [7:0] exp_v[8];
    logic       exp_l[8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic load_key(input string tag, input logic [31:0] k);
        for (int i = 0; i < 4; i++) begin
            key_load = 1'b1;
            key_in   = k[31-8*i -: 8];
            step();
            chk($sformatf("%s_kv%0d", tag, i), 32'(o_key_valid), 32'(i == 3));
        end
        key_load = 1'b0;
    endtask

    task automatic send(input string tag, input int n, input bit last_en, input int stall,
                        input int key_pulse_at, input bit trailer);
        for (int i = 0; i < n; i++) begin
            msg_valid = 1'b1;
            msg_data  = msg_v[i];
            msg_last  = last_en && (i == n - 1);
            if (i == 1) begin
                for (int s = 0; s < stall; s++) begin
                    out_ready = 1'b0;
                    #1;
                    chk($sformatf("%s_stall_rdy%0d", tag, s), 32'(o_msg_ready), 32'd0);
                    chk($sformatf("%s_stall_dat%0d", tag, s), 32'(o_out_data), 32'(exp_v[0]));
                    step();
                end
                out_ready = 1'b1;
            end
            key_load = (i == key_pulse_at);
            key_in   = 8'hFF;
            #1;
            chk($sformatf("%s_rdy%0d", tag, i), 32'(o_msg_ready), 32'd1);
            step();
            key_load = 1'b0;
            chk($sformatf("%s_vld%0d", tag, i), 32'(o_out_valid), 32'd1);
            chk($sformatf("%s_dat%0d", tag, i), 32'(o_out_data), 32'(exp_v[i]));
            chk($sformatf("%s_lst%0d", tag, i), 32'(o_out_last), 32'(exp_l[i]));
        end
        msg_valid = 1'b0;
        msg_last  = 1'b0;
        if (trailer) begin
            step();
            chk({tag, "_drain"}, 32'(o_out_valid), 32'd0);
            chk({tag, "_done"}, 32'(o_frame_done), 32'(exp_l[n-1]));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sel = 1'b0; rst_a = 1'b0; rst_b = 1'b0; ena = 1'b1;
        key_load = 1'b0; key_in = '0; msg_valid = 1'b0; msg_data = '0; msg_last = 1'b0;
        out_ready = 1'b1;
        step(); step();
        chk("rst_key_valid", 32'(o_key_valid), 32'd0);
        chk("rst_out_valid", 32'(o_out_valid), 32'd0);
        chk("rst_out_data", 32'(o_out_data), 32'd0);
        chk("rst_out_last", 32'(o_out_last), 32'd0);
        chk("rst_frame_done", 32'(o_frame_done), 32'd0);
        chk("rst_overflow", 32'(o_overflow), 32'd0);
        rst_a = 1'b1;
        msg_valid = 1'b1;
        step();
        chk("nokey_ready", 32'(o_msg_ready), 32'd0);
        msg_valid = 1'b0;

        // Basic frame, key DEADBEEF.
        load_key("k1", 32'hDEADBEEF);
        msg_v = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00, 8'h00};
        exp_v = '{8'hDE, 8'hBC, 8'h9C, 8'hDC, (ROLL ? 8'hF9 : 8'h9A), 8'h00, 8'h00, 8'h00};
        exp_l = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        send("f1", 5, 1'b1, 0, -1, 1'b1);
        step();
        chk("f1_done_pulse", 32'(o_frame_done), 32'd0);

        // Global enable low blocks acceptance.
        ena = 1'b0; msg_valid = 1'b1; msg_data = 8'h55;
        #1;
        chk("ena_ready", 32'(o_msg_ready), 32'd0);
        step();
        chk("ena_hold_valid", 32'(o_out_valid), 32'd0);
        ena = 1'b1; msg_valid = 1'b0;

        // Backpressure after the first beat.
        send("f2", 5, 1'b1, 3, -1, 1'b1);

        // key_load during RUN must be ignored.
        msg_v = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00};
        exp_v = '{8'hDE, 8'hBC, 8'h9C, 8'hDC, 8'h00, 8'h00, 8'h00, 8'h00};
        exp_l = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        send("f3", 4, 1'b1, 0, 1, 1'b1);

        // Rekey in IDLE.
        load_key("k2", 32'h01020304);
        msg_v = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        exp_v = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        exp_l = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        send("f4", 1, 1'b1, 0, -1, 1'b1);

        // Eight zero beats: second key pass rotated only with the roll feature.
        load_key("k3", 32'hDEADBEEF);
        exp_v = '{8'hDE, 8'hAD, 8'hBE, 8'hEF,
                  (ROLL ? 8'hBD : 8'hDE), (ROLL ? 8'h5B : 8'hAD),
                  (ROLL ? 8'h7D : 8'hBE), (ROLL ? 8'hDF : 8'hEF)};
        exp_l = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        send("f5", 8, 1'b1, 0, -1, 1'b1);
        exp_v = '{8'hDE, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        exp_l = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        send("f6", 1, 1'b1, 0, -1, 1'b1);

        // Overflow on the MSG_BITS=32 instance.
        sel = 1'b1; rst_b = 1'b1;
        step();
        load_key("k4", 32'hDEADBEEF);
        exp_v = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hDE, 8'hAD, 8'h00, 8'h00};
        exp_l = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        send("ovf", 6, 1'b0, 0, -1, 1'b1);
        chk("ovf_sticky", 32'(o_overflow), 32'd1);
        chk("ovf_other_inst", 32'(a_overflow), 32'd0);

        // Mid-frame reset of the MSG_BITS=32 instance.
        exp_v = '{8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        exp_l = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        send("pre_rst", 2, 1'b0, 0, -1, 1'b0);
        rst_b = 1'b0;
        step();
        rst_b = 1'b1;
        msg_valid = 1'b1;
        #1;
        chk("mrst_out_valid", 32'(o_out_valid), 32'd0);
        chk("mrst_key_valid", 32'(o_key_valid), 32'd0);
        chk("mrst_overflow", 32'(o_overflow), 32'd0);
        chk("mrst_ready", 32'(o_msg_ready), 32'd0);
        step();
        chk("mrst_ready2", 32'(o_msg_ready), 32'd0);
        msg_valid = 1'b0;
        load_key("k5", 32'hDEADBEEF);
        exp_v = '{8'hDE, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        exp_l = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        send("post_rst", 1, 1'b1, 0, -1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/xor_stream_cipher.md
Name: xor_stream_cipher

Overview:
Parametrised, lane-wide streaming successor to the serial XOR cipher datapath. It loads a repeating key of KEY_BITS, then XORs message beats of LANES bits against successive key slices as they stream through. It does not buffer a whole message. Valid/ready handshakes on input and output let it sit between the pin-level deserialiser front end and the output serialiser, with backpressure.

Parameters:
KEY_BITS, 32, key length in bits; must be a multiple of LANES
LANES, 8, data bits per beat (1 = bit-serial)
MSG_BITS, 512, maximum frame length in bits; must be a multiple of LANES

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
ena  in  1  global enable; when low all state holds
key_load  in  1  key beat strobe
key_in  in  LANES  key beat, MSB slice first
key_valid  out  1  full key held
msg_valid  in  1  message beat valid
msg_data  in  LANES  message beat
msg_last  in  1  last beat of frame
msg_ready  out  1  message beat accepted when msg_valid & msg_ready
out_valid  out  1  ciphertext beat valid
out_data  out  LANES  ciphertext beat
out_last  out  1  last beat of frame
out_ready  in  1  downstream accept
frame_done  out  1  one-cycle pulse when out_last beat is accepted
overflow  out  1  sticky; frame hit MSG_BITS/LANES beats without msg_last

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low. On reset all outputs are 0, the key register is 0, all counters are 0, and the FSM is in NOKEY.
- ena low: no register changes and msg_ready = 0. Outputs hold their values.
- FSM NOKEY: on key_load, shift key_in into the key register (key <= {key, key_in}) and increment key_cnt, then go to LOADK.
- FSM LOADK: each key_load shifts in one more beat. When beat KEY_BITS/LANES is taken, set key_valid = 1, reset key_cnt to 0, and go to IDLE.
- FSM IDLE: key_load clears key_valid, shifts in the beat, and returns to LOADK (this is a rekey). The first accepted msg beat goes to RUN.
- FSM RUN: key_load is ignored. The FSM returns to IDLE once the last beat is accepted at the input.
- msg_ready = ena & key_valid & (state is IDLE or RUN) & (!out_valid | out_ready).
- Accepted beat:
  - out_data <= msg_data ^ key[KEY_BITS-1-LANES*key_ptr -: LANES].
  - out_valid <= 1.
  - out_last <= msg_last | (beat_cnt == MSG_BITS/LANES-1).
  - Latency is exactly 1 cycle.
- key_ptr increments modulo KEY_BITS/LANES and wraps without a bubble.
- On a last beat (including a forced one), key_ptr and beat_cnt return to 0.
- Forced last: if the frame reaches MSG_BITS/LANES beats without msg_last, set overflow (sticky until reset) and force out_last. Following beats start a new frame.
- Output stage:
  - Holds out_data, out_valid and out_last stable while out_valid & !out_ready.
  - Clears out_valid on out_ready when no new beat is accepted the same cycle.
  - Simultaneous accept-in and drain-out gives full throughput, one beat per cycle.
- frame_done pulses in the cycle after the out_last beat handshake completes.
- rst_n low mid-frame: the partial frame is discarded, the key is lost, and key_valid = 0.

Optional Feature:
XOR_CIPHER_KEY_ROLL_EN:
- Defined: each time key_ptr wraps from the last slice to 0 within a frame, the key register rotates left by 1 bit. So successive key passes differ.
- The key restores to the loaded value at frame end. A shadow copy is kept for this.
- Undefined: the key is static and no shadow register is built.

Decomposition:
- Package xor_cipher_pkg holds:
  - the state enum (NOKEY, LOADK, IDLE, RUN)
  - localparams KEY_BEATS = KEY_BITS/LANES and MSG_BEATS = MSG_BITS/LANES
  - pointer width constants via clog2
- One sub-module, xor_key_ring. It owns the key shift register, key_cnt, key_ptr, slice select and the optional roll/shadow logic. The top owns the FSM, beat_cnt and the output register.

Test Plan:
- LANES=8, load key beats DE AD BE EF, then stream 00 11 22 33 44 with last on 44, out_ready=1 -> out_data is DE BC 9C DC 9A, out_last on 9A, frame_done one cycle later, key_valid=1 after the 4th key beat.
- Same frame with out_ready held 0 for 3 cycles after the first beat -> out_data holds DE, msg_ready=0, no beat is lost or duplicated.
- Set MSG_BITS=32 and send 6 beats with no last -> out_last is forced on beat 4, overflow=1, and beat 5 is encrypted with slice DE again.
- key_load pulsed during RUN -> ignored, and ciphertext matches the original key. Rekey in IDLE to 01020304, then send 00 -> out_data is 01.
- rst_n=0 for one cycle after beat 2 -> the next cycle shows out_valid=0, key_valid=0, overflow=0, and msg_ready=0 until the key is reloaded.
- With XOR_CIPHER_KEY_ROLL_EN, key DEADBEEF, 8 zero beats -> beats 4-7 equal BD 5B 7D DF, and the next frame restarts with DE.
